// File: rtl/uart_rcvr_if.sv
// Receiver-side port bundle: serial line in, parallel word plus ready/read handshake and error flags out.
// parity_err_o exists only when UART_RCVR_PARITY_EN is defined.
interface uart_rcvr_if #(
   parameter int WD_SIZE = 8
);
   logic               seri_data_i;
   logic               read_rcv_i;
   logic [WD_SIZE-1:0] bus_data_o;
   logic               rcv_ready_o;
   logic               frame_err_o;
   logic               overrun_err_o;
`ifdef UART_RCVR_PARITY_EN
   logic               parity_err_o;

   modport slave (
      input  seri_data_i,
      input  read_rcv_i,
      output bus_data_o,
      output rcv_ready_o,
      output frame_err_o,
      output overrun_err_o,
      output parity_err_o
   );

   modport master (
      output seri_data_i,
      output read_rcv_i,
      input  bus_data_o,
      input  rcv_ready_o,
      input  frame_err_o,
      input  overrun_err_o,
      input  parity_err_o
   );
`else
   modport slave (
      input  seri_data_i,
      input  read_rcv_i,
      output bus_data_o,
      output rcv_ready_o,
      output frame_err_o,
      output overrun_err_o
   );

   modport master (
      output seri_data_i,
      output read_rcv_i,
      input  bus_data_o,
      input  rcv_ready_o,
      input  frame_err_o,
      input  overrun_err_o
   );
`endif
endinterface

// File: rtl/uart_rcvr.sv
// Oversampling UART receiver (start, WD_SIZE data LSB first, [even parity], stop); word held until read_rcv_i.
// Ready rises ~2+CLKS_PER_BIT/2+(WD_SIZE+1)*CLKS_PER_BIT+1 cycles after the start edge; UART_RCVR_PARITY_EN adds the parity bit.
module uart_rcvr #(
   parameter int WD_SIZE      = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 16
) (
   input logic        clk,
   input logic        rstn,
   uart_rcvr_if.slave bus
);

   localparam int                IDX_W    = $clog2(WD_SIZE + 1);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WD_SIZE - 1);

`ifdef UART_RCVR_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_DONE
   } state_t;
`endif

   state_t             state, state_nxt;
   logic               sync1, rx_s, rx_prev;
   logic               fall;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   bit_idx;
   logic [WD_SIZE-1:0] shreg;
   logic               stop_bit;
   logic               cnt_clr, smp_data, smp_stop, load_out;
`ifdef UART_RCVR_PARITY_EN
   logic               smp_par;
   logic               par_bad;
`endif

   // Synchronizer and edge history idle high so reset never looks like a start edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1   <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= bus.seri_data_i;
         rx_s    <= sync1;
         rx_prev <= rx_s;
      end
   end

   assign fall = ~rx_s & rx_prev;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      smp_data  = 1'b0;
      smp_stop  = 1'b0;
      load_out  = 1'b0;
`ifdef UART_RCVR_PARITY_EN
      smp_par   = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            cnt_clr = 1'b1;
            if (fall) state_nxt = S_START;
         end
         S_START: begin
            if (cnt == HALF_CNT) begin
               cnt_clr   = 1'b1;
               state_nxt = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt == FULL_CNT) begin
               cnt_clr  = 1'b1;
               smp_data = 1'b1;
`ifdef UART_RCVR_PARITY_EN
               if (bit_idx == LAST_IDX) state_nxt = S_PARITY;
`else
               if (bit_idx == LAST_IDX) state_nxt = S_STOP;
`endif
            end
         end
`ifdef UART_RCVR_PARITY_EN
         S_PARITY: begin
            if (cnt == FULL_CNT) begin
               cnt_clr   = 1'b1;
               smp_par   = 1'b1;
               state_nxt = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cnt == FULL_CNT) begin
               cnt_clr   = 1'b1;
               smp_stop  = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            cnt_clr   = 1'b1;
            load_out  = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            cnt_clr   = 1'b1;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         stop_bit <= 1'b0;
      end else begin
         cnt <= cnt_clr ? '0 : cnt + 1'b1;
         if (smp_data)              bit_idx <= bit_idx + 1'b1;
         else if (state != S_DATA)  bit_idx <= '0;
         if (smp_data) shreg    <= {rx_s, shreg[WD_SIZE-1:1]};
         if (smp_stop) stop_bit <= rx_s;
      end
   end

`ifdef UART_RCVR_PARITY_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)        par_bad <= 1'b0;
      else if (smp_par) par_bad <= (^shreg) ^ rx_s;
   end
`endif

   // A completing word beats a same-cycle read: the new word stays pending.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.bus_data_o    <= '0;
         bus.rcv_ready_o   <= 1'b0;
         bus.frame_err_o   <= 1'b0;
         bus.overrun_err_o <= 1'b0;
`ifdef UART_RCVR_PARITY_EN
         bus.parity_err_o  <= 1'b0;
`endif
      end else if (load_out) begin
         bus.bus_data_o    <= shreg;
         bus.rcv_ready_o   <= 1'b1;
         bus.frame_err_o   <= ~stop_bit;
         bus.overrun_err_o <= bus.rcv_ready_o & ~bus.read_rcv_i;
`ifdef UART_RCVR_PARITY_EN
         bus.parity_err_o  <= par_bad;
`endif
      end else if (bus.read_rcv_i && bus.rcv_ready_o) begin
         bus.rcv_ready_o   <= 1'b0;
         bus.frame_err_o   <= 1'b0;
         bus.overrun_err_o <= 1'b0;
`ifdef UART_RCVR_PARITY_EN
         bus.parity_err_o  <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_uart_rcvr.sv
// Directed bench for uart_rcvr: reset, frames, glitch, framing error, overrun, parity, mid-frame reset.
module tb_uart_rcvr;

   localparam int WD  = 8;
   localparam int CB  = 16;
`ifdef UART_RCVR_PARITY_EN
   localparam int NBITS = WD + 3;
   localparam int LAT   = 2 + CB / 2 + (WD + 1) * CB + 1 + CB;
`else
   localparam int NBITS = WD + 2;
   localparam int LAT   = 2 + CB / 2 + (WD + 1) * CB + 1;
`endif

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   cyc  = 0;
   int   fall_cyc = 0;
   int   rdy_cyc  = -1;
   logic rdy_q    = 1'b0;
   int   n_asrt   = 0;
   int   n_fail   = 0;

   uart_rcvr_if #(.WD_SIZE(WD)) u_if ();

   uart_rcvr #(.WD_SIZE(WD), .CLKS_PER_BIT(CB), .CNT_W(16)) u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (u_if.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record the cycle of each rising edge of rcv_ready_o.
   always @(negedge clk) begin
      if (u_if.rcv_ready_o && !rdy_q) rdy_cyc = cyc;
      rdy_q = u_if.rcv_ready_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic pulse_read();
      @(negedge clk);
      u_if.read_rcv_i = 1'b1;
      @(negedge clk);
      u_if.read_rcv_i = 1'b0;
   endtask

   // Drives one frame; rd_at >= 0 pulses read_rcv_i on that cycle offset from the start edge.
   task automatic send_frame(input logic [WD-1:0] d, input logic stop, input logic bad_par, input int rd_at);
      logic bits [0:11];
      bits[0] = 1'b0;
      for (int i = 0; i < WD; i++) bits[1+i] = d[i];
`ifdef UART_RCVR_PARITY_EN
      bits[WD+1] = (^d) ^ bad_par;
`else
      bits[WD+1] = stop ^ bad_par ^ bad_par;
`endif
      bits[NBITS-1] = stop;
      rdy_cyc = -1;
      for (int k = 0; k < NBITS * CB; k++) begin
         @(negedge clk);
         if (k == 0) fall_cyc = cyc + 1;
         u_if.seri_data_i = bits[k / CB];
         u_if.read_rcv_i  = (k == rd_at);
      end
      @(negedge clk);
      u_if.read_rcv_i = 1'b0;
   endtask

   task automatic check_latency(input string tag);
      int lat;
      lat = (rdy_cyc < 0) ? -1 : rdy_cyc - fall_cyc;
      check(tag, (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);
   endtask

   initial begin
      u_if.seri_data_i = 1'b1;
      u_if.read_rcv_i  = 1'b0;
      idle(5);
      check("rst_ready", {31'd0, u_if.rcv_ready_o}, 32'd0);
      check("rst_data",  {24'd0, u_if.bus_data_o},  32'd0);
      rstn = 1'b1;
      idle(100);
      check("idle_ready",   {31'd0, u_if.rcv_ready_o},   32'd0);
      check("idle_data",    {24'd0, u_if.bus_data_o},    32'd0);
      check("idle_frame",   {31'd0, u_if.frame_err_o},   32'd0);
      check("idle_overrun", {31'd0, u_if.overrun_err_o}, 32'd0);

      // Single frame 0x4F
      send_frame(8'h4F, 1'b1, 1'b0, -1);
      check_latency("f1_latency");
      check("f1_data",    {24'd0, u_if.bus_data_o},    32'h4F);
      check("f1_ready",   {31'd0, u_if.rcv_ready_o},   32'd1);
      check("f1_frame",   {31'd0, u_if.frame_err_o},   32'd0);
      check("f1_overrun", {31'd0, u_if.overrun_err_o}, 32'd0);
      pulse_read();
      check("f1_rd_ready", {31'd0, u_if.rcv_ready_o}, 32'd0);
      check("f1_rd_data",  {24'd0, u_if.bus_data_o},  32'h4F);
      idle(20);

      // Glitch of 4 cycles then a clean 0xA5
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         u_if.seri_data_i = 1'b0;
      end
      @(negedge clk);
      u_if.seri_data_i = 1'b1;
      idle(40);
      check("glitch_ready", {31'd0, u_if.rcv_ready_o}, 32'd0);
      send_frame(8'hA5, 1'b1, 1'b0, -1);
      check_latency("a5_latency");
      check("a5_data",  {24'd0, u_if.bus_data_o},  32'hA5);
      check("a5_ready", {31'd0, u_if.rcv_ready_o}, 32'd1);
      check("a5_frame", {31'd0, u_if.frame_err_o}, 32'd0);
      pulse_read();
      idle(20);

      // Framing error: stop bit low, line then held low (break)
      send_frame(8'h3C, 1'b0, 1'b0, -1);
      check("fe_data",  {24'd0, u_if.bus_data_o},  32'h3C);
      check("fe_ready", {31'd0, u_if.rcv_ready_o}, 32'd1);
      check("fe_frame", {31'd0, u_if.frame_err_o}, 32'd1);
      pulse_read();
      check("fe_rd_frame", {31'd0, u_if.frame_err_o}, 32'd0);
      idle(200);
      check("break_ready", {31'd0, u_if.rcv_ready_o}, 32'd0);
      u_if.seri_data_i = 1'b1;
      idle(40);
      check("break_release_ready", {31'd0, u_if.rcv_ready_o}, 32'd0);

      // Overrun: two frames without a read
      send_frame(8'h11, 1'b1, 1'b0, -1);
      idle(10);
      send_frame(8'h22, 1'b1, 1'b0, -1);
      check("ovr_data",    {24'd0, u_if.bus_data_o},    32'h22);
      check("ovr_ready",   {31'd0, u_if.rcv_ready_o},   32'd1);
      check("ovr_overrun", {31'd0, u_if.overrun_err_o}, 32'd1);
      pulse_read();
      check("ovr_rd_overrun", {31'd0, u_if.overrun_err_o}, 32'd0);
      check("ovr_rd_ready",   {31'd0, u_if.rcv_ready_o},   32'd0);
      idle(10);

      // Read on the exact completion cycle of the second frame
      send_frame(8'h11, 1'b1, 1'b0, -1);
      idle(10);
      send_frame(8'h22, 1'b1, 1'b0, LAT);
      check("sim_data",    {24'd0, u_if.bus_data_o},    32'h22);
      check("sim_ready",   {31'd0, u_if.rcv_ready_o},   32'd1);
      check("sim_overrun", {31'd0, u_if.overrun_err_o}, 32'd0);
      pulse_read();
      idle(10);

`ifdef UART_RCVR_PARITY_EN
      send_frame(8'h4F, 1'b1, 1'b0, -1);
      check("par_ok_data", {24'd0, u_if.bus_data_o},   32'h4F);
      check("par_ok_err",  {31'd0, u_if.parity_err_o}, 32'd0);
      pulse_read();
      idle(10);
      send_frame(8'h4F, 1'b1, 1'b1, -1);
      check("par_bad_err",   {31'd0, u_if.parity_err_o}, 32'd1);
      check("par_bad_ready", {31'd0, u_if.rcv_ready_o},  32'd1);
      pulse_read();
      check("par_rd_err", {31'd0, u_if.parity_err_o}, 32'd0);
      idle(10);
`endif

      // Reset asserted mid-DATA while a word is pending
      send_frame(8'h96, 1'b1, 1'b0, -1);
      check("pre_rst_data", {24'd0, u_if.bus_data_o}, 32'h96);
      idle(10);
      for (int k = 0; k < 3 * CB; k++) begin
         @(negedge clk);
         u_if.seri_data_i = 1'b0;
      end
      rstn = 1'b0;
      #1;
      check("mid_rst_ready", {31'd0, u_if.rcv_ready_o}, 32'd0);
      check("mid_rst_data",  {24'd0, u_if.bus_data_o},  32'd0);
      u_if.seri_data_i = 1'b1;
      idle(3);
      rstn = 1'b1;
      idle(CB * NBITS);
      check("post_rst_ready", {31'd0, u_if.rcv_ready_o}, 32'd0);
      send_frame(8'h5A, 1'b1, 1'b0, -1);
      check_latency("post_rst_latency");
      check("post_rst_data", {24'd0, u_if.bus_data_o}, 32'h5A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rcvr.md
Name: uart_rcvr

Overview:
Serial-to-parallel UART receiver. It is the receive counterpart of uart_xmtr and uses the same frame format: 1 start bit (0), WD_SIZE data bits LSB first, then 1 stop bit (1). It oversamples the asynchronous seri_data_i line and presents each received word on a parallel bus with a ready/read handshake. Its bus side connects to the same APB-style host logic that loads uart_xmtr.

Parameters:
WD_SIZE, 8, data bits per frame (5..9)
CLKS_PER_BIT, 16, clk cycles per bit period; even number, minimum 8
CNT_W, 16, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
seri_data_i  input  1  asynchronous serial line; idles high
read_rcv_i  input  1  single-cycle pulse from host; acknowledges and clears rcv_ready_o
bus_data_o  output  WD_SIZE  last received word, LSB = first data bit
rcv_ready_o  output  1  high while bus_data_o holds a word not yet read
frame_err_o  output  1  stop bit of last frame sampled 0; sticky until read
overrun_err_o  output  1  word completed while rcv_ready_o was high; sticky until read
parity_err_o  output  1  present only with UART_RCVR_PARITY_EN (see Optional Feature)

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Internally, both synchronizer flops reset to 1 and the counter and bit index reset to 0. Reset is asynchronous and may be asserted mid-frame; the partial frame is discarded.
- Input path: seri_data_i passes through a 2-flop synchronizer (rx_s). A falling edge is detected when rx_s is 0 and the previous rx_s was 1.
- Counter: cnt counts clk cycles inside each state and clears on every state change or bit sample.
- IDLE: on a falling edge of rx_s, go to START with cnt=0. A line held low (break) is never treated as a new start; the line must return high first.
- START: when cnt = CLKS_PER_BIT/2-1, sample rx_s. If 0, go to DATA with cnt=0 and bit index 0. If 1, the edge was a glitch: go back to IDLE with no flags set.
- DATA: when cnt = CLKS_PER_BIT-1, sample rx_s into the shift register (LSB first) and increment the bit index. After WD_SIZE samples, go to STOP (or to PARITY when the macro is defined).
- STOP: when cnt = CLKS_PER_BIT-1, sample rx_s, then go to IDLE on the next cycle. On that same cycle:
  - bus_data_o <= shift register;
  - rcv_ready_o <= 1;
  - frame_err_o <= ~stop_sample;
  - overrun_err_o <= 1 if rcv_ready_o was already 1 and read_rcv_i is not asserted in this cycle.
- Overrun: the new word always overwrites bus_data_o; the last frame wins.
- Framing error: the word is still delivered and rcv_ready_o is still set.
- read_rcv_i: clears rcv_ready_o, frame_err_o, overrun_err_o and parity_err_o on the next edge. bus_data_o is held.
- Simultaneous read_rcv_i and word completion: the completion wins. rcv_ready_o stays 1 with the new word and error flags, and overrun is not flagged.
- read_rcv_i while rcv_ready_o is 0: no effect.
- Latency: rcv_ready_o rises 2 + (CLKS_PER_BIT/2) + (WD_SIZE+1)*CLKS_PER_BIT + 1 cycles after the falling edge on seri_data_i, ±1 cycle for synchronizer phase.
- Timing tolerance: sampling at mid-bit tolerates ±(CLKS_PER_BIT/2-1) cycles of accumulated skew per frame.

Optional Feature:
Macro UART_RCVR_PARITY_EN (define in uart_defines.v).
- Defined:
  - A PARITY state follows DATA. It samples one extra bit after CLKS_PER_BIT cycles, then goes to STOP.
  - Parity is even: the XOR of the data bits and the parity bit must be 0.
  - parity_err_o is loaded at stop time alongside frame_err_o and clears on read_rcv_i.
  - The frame is WD_SIZE+3 bits long and the latency grows by CLKS_PER_BIT.
- Undefined: the PARITY state and the parity_err_o port do not exist, and the frame is WD_SIZE+2 bits.

Test Plan:
1. Reset and idle: hold rstn=0 with the line high, then release and wait 100 cycles -> all outputs stay 0 and no spurious ready.
2. Single frame (CLKS_PER_BIT=16): send 0x4F (bits 1,1,1,1,0,0,1,0) with a valid stop bit -> bus_data_o=8'h4F, rcv_ready_o=1 and no errors within latency ±1. Then pulse read_rcv_i -> rcv_ready_o=0 next cycle and bus_data_o still 8'h4F.
3. Glitch rejection: drive the line low for 4 cycles, then high -> the receiver returns to IDLE and rcv_ready_o stays 0. A following 0xA5 frame is then received correctly.
4. Framing error: send 0x3C with the stop bit held 0, then release the line high -> bus_data_o=8'h3C, rcv_ready_o=1, frame_err_o=1. With the line held low afterwards, no second frame starts until the line goes high.
5. Overrun and simultaneous read:
   - Send 0x11 then 0x22 with no read -> bus_data_o=8'h22 and overrun_err_o=1.
   - Repeat with read_rcv_i pulsed on the exact completion cycle of the second frame -> rcv_ready_o=1 and overrun_err_o=0.
6. Parity (macro defined): send 0x4F with parity bit 1 -> parity_err_o=0. Send it again with parity bit 0 -> parity_err_o=1. Also assert rstn mid-DATA -> all outputs return to 0 immediately.
